// File: rtl/sha3_job_arbiter_if.sv
// Bundle between the requesters, the SHA3 job arbiter and the shared
// burst-read + Keccak datapath. The arbiter connects through the master
// modport; the requesters/datapath (or a bench) sit on the slave side.
interface sha3_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        job_done;
  logic [NUM_REQ-1:0]        job_err;
  logic                      busy;
  logic [2:0]                grant_id;
  logic                      dp_clear;
  logic                      hash_start;
  logic [LEN_W-1:0]          hash_len;
  logic                      hash_out_ready;
  logic                      rd_ready;
  logic                      rd_init;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      rd_active;
  logic                      rd_done;

  modport master (
    input  req_valid, req_addr, req_len, hash_out_ready, rd_ready, rd_active, rd_done,
    output req_ack, job_done, job_err, busy, grant_id, dp_clear, hash_start, hash_len,
           rd_init, rd_addr
  );

  modport slave (
    output req_valid, req_addr, req_len, hash_out_ready, rd_ready, rd_active, rd_done,
    input  req_ack, job_done, job_err, busy, grant_id, dp_clear, hash_start, hash_len,
           rd_init, rd_addr
  );
endinterface

// File: rtl/sha3_job_arbiter.sv
// Round-robin job arbiter in front of one shared SHA3 datapath. One job runs
// at a time: clear the datapath, start the hasher with the job length, fetch
// the job data as single-outstanding bursts, wait for the digest, then report
// done (or err for an empty job) back to the owning requester.
module sha3_job_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int BURST_BYTES = 16
) (
  input  logic               clk,
  input  logic               reset,
  sha3_job_arbiter_if.master bus
);
  localparam int          BURST_SH  = $clog2(BURST_BYTES);
  // One extra bit so a near-full-scale length still rounds up without overflow.
  localparam int          CNT_W     = LEN_W + 1;
  localparam int unsigned NUM_REQ_U = NUM_REQ;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ACK    = 4'd1,
    ERR    = 4'd2,
    CLR    = 4'd3,
    START  = 4'd4,
    ISSUE  = 4'd5,
    WAIT_A = 4'd6,
    WAIT_D = 4'd7,
    WAIT_H = 4'd8,
    DONE   = 4'd9
  } state_t;

  state_t             state_r;
  logic [2:0]         rr_ptr_r;
  logic [ADDR_W-1:0]  job_addr_r;
  logic [LEN_W-1:0]   job_len_r;
  logic [CNT_W-1:0]   bursts_left_r;
  logic [NUM_REQ-1:0] req_ack_r;
  logic [NUM_REQ-1:0] job_done_r;
  logic [NUM_REQ-1:0] job_err_r;
  logic               busy_r;
  logic [2:0]         grant_id_r;
  logic               dp_clear_r;
  logic               hash_start_r;
  logic [LEN_W-1:0]   hash_len_r;
  logic               rd_init_r;
  logic [ADDR_W-1:0]  rd_addr_r;

  logic [7:0]         valid_pad_s;
  logic               win_found_s;
  logic [2:0]         win_idx_s;

  // Requester index base+off, wrapping at NUM_REQ (off is always < NUM_REQ).
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ_U) begin
      sum = sum - NUM_REQ_U;
    end
    return sum[2:0];
  endfunction

  // One-hot requester vector for a given index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
    logic [7:0] vec;
    vec = 8'd1 << idx;
    return vec[NUM_REQ-1:0];
  endfunction

  // Number of bursts covering len bytes, rounded up.
  function automatic logic [CNT_W-1:0] burst_count(input logic [LEN_W-1:0] len);
    logic [CNT_W-1:0] padded;
    padded = {1'b0, len} + CNT_W'(BURST_BYTES - 1);
    return padded >> BURST_SH;
  endfunction

  assign valid_pad_s = 8'(bus.req_valid);

  // Round-robin scan: first pending request at or after rr_ptr_r wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    for (int unsigned k = 0; k < NUM_REQ_U; k++) begin
      if (!win_found_s && valid_pad_s[wrap_idx(rr_ptr_r, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Job sequencer: arbitration, datapath control pulses and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      rr_ptr_r      <= 3'd0;
      job_addr_r    <= {ADDR_W{1'b0}};
      job_len_r     <= {LEN_W{1'b0}};
      bursts_left_r <= {CNT_W{1'b0}};
      req_ack_r     <= {NUM_REQ{1'b0}};
      job_done_r    <= {NUM_REQ{1'b0}};
      job_err_r     <= {NUM_REQ{1'b0}};
      busy_r        <= 1'b0;
      grant_id_r    <= 3'd0;
      dp_clear_r    <= 1'b0;
      hash_start_r  <= 1'b0;
      hash_len_r    <= {LEN_W{1'b0}};
      rd_init_r     <= 1'b0;
      rd_addr_r     <= {ADDR_W{1'b0}};
    end else begin
      req_ack_r    <= {NUM_REQ{1'b0}};
      job_done_r   <= {NUM_REQ{1'b0}};
      job_err_r    <= {NUM_REQ{1'b0}};
      dp_clear_r   <= 1'b0;
      hash_start_r <= 1'b0;
      rd_init_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            job_addr_r <= bus.req_addr[win_idx_s*ADDR_W +: ADDR_W];
            job_len_r  <= bus.req_len[win_idx_s*LEN_W +: LEN_W];
            req_ack_r  <= onehot(win_idx_s);
            grant_id_r <= win_idx_s;
            rr_ptr_r   <= wrap_idx(win_idx_s, 32'd1);
            busy_r     <= 1'b1;
            state_r    <= ACK;
          end else begin
            state_r <= IDLE;
          end
        end
        ACK: begin
          state_r <= (job_len_r == {LEN_W{1'b0}}) ? ERR : CLR;
        end
        ERR: begin
          job_err_r <= onehot(grant_id_r);
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        CLR: begin
          dp_clear_r <= 1'b1;
          state_r    <= START;
        end
        START: begin
          hash_start_r  <= 1'b1;
          hash_len_r    <= job_len_r;
          bursts_left_r <= burst_count(job_len_r);
          rd_addr_r     <= job_addr_r;
          state_r       <= ISSUE;
        end
        ISSUE: begin
          if (bursts_left_r == {CNT_W{1'b0}}) begin
            state_r <= WAIT_H;
          end else if (bus.rd_ready) begin
            rd_init_r <= 1'b1;
            state_r   <= WAIT_A;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT_A: begin
          // A burst may start and finish in the same cycle.
          if (bus.rd_done) begin
            rd_addr_r     <= rd_addr_r + ADDR_W'(BURST_BYTES);
            bursts_left_r <= bursts_left_r - CNT_W'(1);
            state_r       <= ISSUE;
          end else if (bus.rd_active) begin
            state_r <= WAIT_D;
          end else begin
            state_r <= WAIT_A;
          end
        end
        WAIT_D: begin
          if (bus.rd_done) begin
            rd_addr_r     <= rd_addr_r + ADDR_W'(BURST_BYTES);
            bursts_left_r <= bursts_left_r - CNT_W'(1);
            state_r       <= ISSUE;
          end else begin
            state_r <= WAIT_D;
          end
        end
        WAIT_H: begin
          state_r <= bus.hash_out_ready ? DONE : WAIT_H;
        end
        DONE: begin
          job_done_r <= onehot(grant_id_r);
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack    = req_ack_r;
  assign bus.job_done   = job_done_r;
  assign bus.job_err    = job_err_r;
  assign bus.busy       = busy_r;
  assign bus.grant_id   = grant_id_r;
  assign bus.dp_clear   = dp_clear_r;
  assign bus.hash_start = hash_start_r;
  assign bus.hash_len   = hash_len_r;
  assign bus.rd_init    = rd_init_r;
  assign bus.rd_addr    = rd_addr_r;
endmodule
